// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder and its store-trace FIFO.
package dm_pkg;
  localparam int BYTE_LANES = 4;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [31:0]           pc;
    logic [31:0]           addr;
    logic [31:0]           data;
    logic [BYTE_LANES-1:0] byteen;
  } trc_rec_t;

  // Replace the enabled byte lanes of old_w with those of new_w.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [BYTE_LANES-1:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < BYTE_LANES; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dm_trace_fifo.sv
// Store-trace FIFO: wrap-bit pointers, head gated to zero while empty, saturating drop counter.
module dm_trace_fifo import dm_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int W     = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  output logic                  full,
  input  logic                  pop,
  output logic [W-1:0]          pop_data,
  output logic                  empty,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_pop, do_push, drop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && !do_push;
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
endmodule

// File: rtl/dm_responder.sv
// M-stage data-memory responder: zero-latency reads, byte-enabled stores, optional store trace.
// Define DM_TRACE_EN to build the trace FIFO; otherwise trace outputs are tied to zero.
module dm_responder import dm_pkg::*; #(
  parameter int          WORD_ADDR_W = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          TRACE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           m_data_addr,
  input  logic [31:0]           m_data_wdata,
  input  logic [3:0]            m_data_byteen,
  input  logic [31:0]           m_inst_addr,
  output logic [31:0]           m_data_rdata,
  output logic                  trc_valid,
  input  logic                  trc_ready,
  output logic [31:0]           trc_pc,
  output logic [31:0]           trc_addr,
  output logic [31:0]           trc_data,
  output logic [3:0]            trc_byteen,
  output logic [DROP_CNT_W-1:0] trc_drop_cnt,
  output logic                  err_range
);
  localparam int DEPTH = 1 << WORD_ADDR_W;

  logic [31:0]            mem [DEPTH];
  logic [31:0]            word_off, rd_word, merged;
  logic [WORD_ADDR_W-1:0] idx;
  logic                   in_range, store, store_oor;

  assign word_off  = (m_data_addr - BASE_ADDR) >> 2;
  assign idx       = word_off[WORD_ADDR_W-1:0];
  assign in_range  = (m_data_addr >= BASE_ADDR) &&
                     ({1'b0, word_off} < (33'd1 << WORD_ADDR_W));
  assign rd_word   = mem[idx];
  assign merged    = merge_lanes(rd_word, m_data_wdata, m_data_byteen);
  assign store     = (|m_data_byteen) && in_range;
  assign store_oor = (|m_data_byteen) && !in_range;

  assign m_data_rdata = in_range ? rd_word : '0;

  // RAM contents are architecturally zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (store) begin
      mem[idx] <= merged;
    end
  end

  // Only stores can trip the flag; speculative load addresses are harmless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          err_range <= 1'b0;
    else if (store_oor) err_range <= 1'b1;
  end

`ifdef DM_TRACE_EN
  trc_rec_t push_rec, head;
  logic     fifo_empty, unused_full;

  assign push_rec = '{pc: m_inst_addr, addr: m_data_addr & ~32'h3,
                      data: merged, byteen: m_data_byteen};

  dm_trace_fifo #(.DEPTH(TRACE_DEPTH), .W($bits(trc_rec_t))) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (store),
    .push_data (push_rec),
    .full      (unused_full),
    .pop       (trc_ready),
    .pop_data  (head),
    .empty     (fifo_empty),
    .drop_cnt  (trc_drop_cnt)
  );

  assign trc_valid  = !fifo_empty;
  assign trc_pc     = head.pc;
  assign trc_addr   = head.addr;
  assign trc_data   = head.data;
  assign trc_byteen = head.byteen;
`else
  logic unused_trc;

  assign unused_trc   = ^{trc_ready, m_inst_addr};
  assign trc_valid    = 1'b0;
  assign trc_pc       = '0;
  assign trc_addr     = '0;
  assign trc_data     = '0;
  assign trc_byteen   = '0;
  assign trc_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_dm_responder.sv
// Randomised bench for dm_responder against a queue/array reference model of the data port and trace.
module tb_dm_responder;
  localparam int QDEPTH = 8;
  localparam int NWORDS = 4096;
`ifdef DM_TRACE_EN
  localparam bit TRC = 1'b1;
`else
  localparam bit TRC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
  logic [3:0]  m_data_byteen;
  logic        trc_valid, trc_ready, err_range;
  logic [31:0] trc_pc, trc_addr, trc_data;
  logic [3:0]  trc_byteen;
  logic [15:0] trc_drop_cnt;

  always #5 clk = ~clk;

  dm_responder dut (
    .clk(clk), .reset(reset),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
    .m_data_rdata(m_data_rdata),
    .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_pc(trc_pc), .trc_addr(trc_addr), .trc_data(trc_data),
    .trc_byteen(trc_byteen), .trc_drop_cnt(trc_drop_cnt),
    .err_range(err_range)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } rec_t;

  logic [31:0] m_mem [NWORDS];
  rec_t        q[$];
  int unsigned m_drops;
  bit          m_err;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'(NWORDS * 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NWORDS; i++) m_mem[i] = '0;
    q.delete();
    m_drops = 0;
    m_err   = 1'b0;
  endtask

  task automatic drv(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input logic [31:0] pc, input logic rdy);
    m_data_addr   = a;
    m_data_wdata  = wd;
    m_data_byteen = be;
    m_inst_addr   = pc;
    trc_ready     = rdy;
  endtask

  // One clock edge: model consequences are computed from pre-edge inputs, committed after.
  task automatic tick();
    bit          pop, st, oor;
    rec_t        r;
    logic [31:0] w, mask;
    int          wi;
    pop = trc_ready && (q.size() != 0);
    st  = (m_data_byteen != 0) && in_rng(m_data_addr);
    oor = (m_data_byteen != 0) && !in_rng(m_data_addr);
    wi  = int'(m_data_addr[13:2]);
    mask = {{8{m_data_byteen[3]}}, {8{m_data_byteen[2]}},
            {8{m_data_byteen[1]}}, {8{m_data_byteen[0]}}};
    w = (m_mem[wi] & ~mask) | (m_data_wdata & mask);
    r = '{m_inst_addr, m_data_addr & ~32'h3, w, m_data_byteen};
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (oor) m_err = 1'b1;
    if (st) begin
      m_mem[wi] = w;
      if (TRC) begin
        if (q.size() < QDEPTH) q.push_back(r);
        else if (m_drops < 65535) m_drops++;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_rd;
    rec_t        h;
    #1;
    exp_rd = in_rng(m_data_addr) ? m_mem[int'(m_data_addr[13:2])] : 32'h0;
    h = (q.size() != 0) ? q[0] : '{32'h0, 32'h0, 32'h0, 4'h0};
    chk("rdata",  m_data_rdata, exp_rd);
    chk("valid",  32'(trc_valid), 32'(q.size() != 0));
    chk("pc",     trc_pc, h.pc);
    chk("addr",   trc_addr, h.addr);
    chk("data",   trc_data, h.data);
    chk("byteen", 32'(trc_byteen), 32'(h.be));
    chk("drops",  32'(trc_drop_cnt), m_drops);
    chk("err",    32'(err_range), 32'(m_err));
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    reset = 1'b1;
    drv(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all();

    // Full-word store then partial merge.
    drv(32'h10, 32'h12345678, 4'hF, 32'h3010, 1'b0);
    tick();
    drv(32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
    check_all();
    chk("ld_full", m_data_rdata, 32'h12345678);
    chk("trc_pc0", trc_pc, TRC ? 32'h3010 : 32'h0);
    chk("trc_dat0", trc_data, TRC ? 32'h12345678 : 32'h0);
    drv(32'h12, 32'h0000AB00, 4'b0010, 32'h3014, 1'b0);
    tick();
    drv(32'h10, 32'h0, 4'h0, 32'h0, 1'b1);
    check_all();
    chk("ld_merge", m_data_rdata, 32'h1234AB78);
    tick(); check_all();
    chk("trc_dat1", trc_data, TRC ? 32'h1234AB78 : 32'h0);
    chk("trc_adr1", trc_addr, TRC ? 32'h10 : 32'h0);
    tick(); check_all();
    chk("drained0", 32'(trc_valid), 32'h0);

    // Nine stores into an 8-deep trace with the consumer stalled.
    for (int i = 0; i < 9; i++) begin
      drv(32'h100 + 32'(4 * i), $urandom, 4'hF, 32'h4000 + 32'(4 * i), 1'b0);
      tick(); check_all();
    end
    chk("drop1", 32'(trc_drop_cnt), TRC ? 32'd1 : 32'd0);
    drv(32'h200, $urandom, 4'hF, 32'h4100, 1'b1);
    tick(); check_all();
    chk("full_pushpop", 32'(trc_drop_cnt), TRC ? 32'd1 : 32'd0);
    drv(32'h100, 32'h0, 4'h0, 32'h0, 1'b1);
    for (int n = 0; n < 20 && q.size() != 0; n++) begin
      tick(); check_all();
    end
    chk("drained1", 32'(trc_valid), 32'h0);

    // Push into an empty FIFO while ready is already high.
    drv(32'h300, 32'hCAFEF00D, 4'hF, 32'h5000, 1'b1);
    tick();
    drv(32'h300, 32'h0, 4'h0, 32'h0, 1'b1);
    check_all();
    tick(); check_all();

    // Out-of-range store.
    drv(32'h4000, 32'hDEADBEEF, 4'hF, 32'h6000, 1'b0);
    check_all();
    tick();
    drv(32'h4000, 32'h0, 4'h0, 32'h0, 1'b0);
    check_all();
    chk("oor_err", 32'(err_range), 32'h1);
    chk("oor_rd", m_data_rdata, 32'h0);
    chk("oor_trc", 32'(trc_valid), 32'h0);
    drv(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    tick(); tick(); check_all();
    chk("err_sticky", 32'(err_range), 32'h1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h4000 + 32'($urandom_range(0, 16'hFFFF));
        1:       a = 32'hFFFF_FFFC;
        default: a = 32'($urandom_range(0, 255));
      endcase
      be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      drv(a, $urandom, be, $urandom, 1'($urandom_range(0, 1)));
      check_all();
      tick();
    end
    check_all();

    // Asynchronous reset mid-cycle with records queued and RAM nonzero.
    for (int i = 0; i < 3; i++) begin
      drv(32'h10 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'hF, 32'h7000 + 32'(4 * i), 1'b0);
      tick();
    end
    drv(32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
    check_all();
    #2 reset = 1'b1;
    model_reset();
    check_all();
    chk("rst_valid", 32'(trc_valid), 32'h0);
    chk("rst_rd10", m_data_rdata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    check_all();
    chk("post_rst_rd10", m_data_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
